// File: rtl/ring_osc_cal_ctrl_if.sv
// ring_osc_cal_ctrl_if: control/status bundle between a calibration host and the ring-oscillator calibration controller
interface ring_osc_cal_ctrl_if;
   logic        cal_start_i;
   logic        auto_en_i;
   logic [15:0] period_i;
   logic [15:0] cal_val_i;
   logic        meas_en_o;
   logic [2:0]  div_sel_o;
   logic [15:0] cal_val_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   modport master (
      output cal_start_i, auto_en_i, period_i, cal_val_i,
      input  meas_en_o, div_sel_o, cal_val_o, busy_o, done_o, err_o
   );
   modport slave (
      input  cal_start_i, auto_en_i, period_i, cal_val_i,
      output meas_en_o, div_sel_o, cal_val_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/ring_osc_cal_ctrl.sv
// ring_osc_cal_ctrl: measures a ring-oscillator count against the 32 kHz reference and picks its divider
module ring_osc_cal_ctrl #(
   parameter int          MEAS_CYCLES = 10,
   parameter logic [15:0] MIN_VALID   = 16'd128,
   parameter logic [15:0] TH5         = 16'd1580,
   parameter logic [15:0] TH6         = 16'd1976,
   parameter logic [15:0] TH7         = 16'd2380,
   parameter logic [15:0] TH8         = 16'd2772
) (
   input logic                clk_32khz_i,
   input logic                reset_i,
   ring_osc_cal_ctrl_if.slave cal
);
   typedef enum logic [2:0] {IDLE, ARM, SAMPLE, CHECK, DECIDE, RELEASE} state_t;
   state_t      state, state_nxt;
   logic [7:0]  tmr;
   logic [15:0] cap_a, auto_cnt;
   logic [1:0]  retry_cnt;
   logic        fail, match, auto_on, auto_tick, trig, reject;
   logic [2:0]  div_calc;
   assign auto_on   = cal.auto_en_i && cal.period_i != 16'd0;
   assign auto_tick = auto_on && state == IDLE && auto_cnt == cal.period_i - 16'd1;
   assign trig      = state == IDLE && (cal.cal_start_i || auto_tick);
   assign match     = cal.cal_val_i == cap_a;
   assign reject    = fail || cap_a < MIN_VALID;
   assign div_calc  = cap_a < TH5 ? 3'b011 : cap_a < TH6 ? 3'b100 : cap_a < TH7 ? 3'b101 :
                      cap_a < TH8 ? 3'b110 : 3'b111;
   assign cal.busy_o = state != IDLE;
   // state register
   always_ff @(posedge clk_32khz_i or posedge reset_i)
      if (reset_i) state <= IDLE;
      else state <= state_nxt;
   // next-state: ARM and RELEASE dwell on tmr, CHECK gives up after the third retry
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = trig ? ARM : IDLE;
         ARM:     state_nxt = tmr == 8'(MEAS_CYCLES - 1) ? SAMPLE : ARM;
         SAMPLE:  state_nxt = CHECK;
         CHECK:   state_nxt = (match || retry_cnt == 2'd3) ? DECIDE : SAMPLE;
         DECIDE:  state_nxt = RELEASE;
         RELEASE: state_nxt = tmr == 8'd1 ? IDLE : RELEASE;
         default: state_nxt = IDLE;
      endcase
   end
   // datapath: dwell timer, capture/compare, registered outputs and the auto-recalibration timer
   always_ff @(posedge clk_32khz_i or posedge reset_i)
      if (reset_i) begin
         tmr           <= '0;
         cap_a         <= '0;
         retry_cnt     <= '0;
         fail          <= 1'b0;
         auto_cnt      <= '0;
         cal.meas_en_o <= 1'b0;
         cal.done_o    <= 1'b0;
         cal.err_o     <= 1'b0;
         cal.div_sel_o <= 3'b111;
         cal.cal_val_o <= '0;
      end else begin
         tmr           <= state_nxt != state ? 8'd0 : tmr + 8'd1;
         cap_a         <= state == SAMPLE ? cal.cal_val_i : cap_a;
         retry_cnt     <= state == RELEASE ? 2'd0 : (state == CHECK && !match) ? retry_cnt + 2'd1 : retry_cnt;
         fail          <= state == CHECK ? (!match && retry_cnt == 2'd3) : fail;
         auto_cnt      <= (cal.busy_o || !auto_on || auto_tick) ? 16'd0 : auto_cnt + 16'd1;
         cal.meas_en_o <= state_nxt inside {ARM, SAMPLE, CHECK};
         cal.done_o    <= state == DECIDE;
         cal.err_o     <= state == DECIDE ? reject : cal.err_o;
         cal.div_sel_o <= (state == DECIDE && !reject) ? div_calc : cal.div_sel_o;
         cal.cal_val_o <= (state == DECIDE && !reject) ? cap_a : cal.cal_val_o;
      end
endmodule
